imem_boot_loader: RTL and testbench



---
 rtl/imem_boot_loader_pkg.sv | 30 +++
 rtl/imem_boot_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_boot_loader.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_pkg.sv
// boot_pkg: shared types and constants for the instruction-memory boot loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   boot_state_t  loader FSM state encoding (IDLE, LOAD, HOLD, RUN, ERROR)
//   WORD_W        instruction word width (32)
//   hold_cnt_w()  width of the post-load hold counter for a given hold length
package boot_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    HOLD  = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } boot_state_t;

  // The hold counter is loaded with hold-1, so it must represent values up to
  // hold-1. A one-bit counter is the floor so the declaration is never empty.
  function automatic int hold_cnt_w(input int hold);
    if (hold <= 2) begin
      return 1;
    end
    return $clog2(hold);
  endfunction

endpackage : boot_pkg

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams a program image into instruction memory from address 0 and releases the core.
// Latency: an accepted beat appears on the imem write port in the following cycle; core_reset falls after a fixed hold.
// Backpressure: load_ready is high only while loading; the loader never stalls mid-image once ready is high.
//
// Optional feature: define BOOT_CHECKSUM_EN to treat the load_last beat as a
// 32-bit additive checksum of the written words instead of a data word.
//
// Ports:
//   clk           single rising-edge clock
//   reset         synchronous active-high reset
//   load_valid    host beat valid
//   load_data     host beat payload (WORD_W bits)
//   load_last     final beat of the image
//   load_ready    loader accepts a beat this cycle (registered)
//   imem_we       instruction-memory write strobe
//   imem_addr     instruction-memory word address
//   imem_wdata    instruction-memory write data
//   core_reset    active-high reset to the processor core
//   done          image loaded and core released
//   error         overflow (or checksum failure), sticky until reset
//   words_loaded  number of words written so far (0..2**ADDR_W)
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int RESET_HOLD = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [WORD_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int HOLD_W = hold_cnt_w(RESET_HOLD);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(RESET_HOLD - 1);

  boot_state_t       state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              accept;
  logic              full;

`ifdef BOOT_CHECKSUM_EN
  logic [WORD_W-1:0] sum;
`endif

  // load_ready is a register that is only high in LOAD, so a handshake can
  // only ever occur while loading.
  assign accept = load_valid & load_ready;
  assign full   = (words_loaded == FULL_COUNT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      load_ready   <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      hold_cnt     <= '0;
`ifdef BOOT_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      // Write strobe is a single-cycle pulse per accepted data beat.
      imem_we <= 1'b0;

      case (state)
        IDLE: begin
          state      <= LOAD;
          load_ready <= 1'b1;
        end

        LOAD: begin
          if (accept) begin
`ifdef BOOT_CHECKSUM_EN
            if (load_last) begin
              // Checksum beat: never written, compared against the sum of
              // everything written so far (zero for an empty image).
              load_ready <= 1'b0;
              if (load_data == sum) begin
                state    <= HOLD;
                hold_cnt <= HOLD_INIT;
              end else begin
                state <= ERROR;
                error <= 1'b1;
              end
            end else if (full) begin
              state      <= ERROR;
              error      <= 1'b1;
              load_ready <= 1'b0;
            end else begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= load_data;
              words_loaded <= words_loaded + 1'b1;
              sum          <= sum + load_data;
            end
`else
            if (full) begin
              // Memory already holds DEPTH words; the beat is dropped.
              state      <= ERROR;
              error      <= 1'b1;
              load_ready <= 1'b0;
            end else begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= load_data;
              words_loaded <= words_loaded + 1'b1;
              if (load_last) begin
                state      <= HOLD;
                hold_cnt   <= HOLD_INIT;
                load_ready <= 1'b0;
              end
            end
`endif
          end
        end

        HOLD: begin
          // The countdown starts once the final write cycle has finished, so
          // the core sees a fully written memory for RESET_HOLD cycles.
          if (!imem_we) begin
            if (hold_cnt == '0) begin
              state      <= RUN;
              core_reset <= 1'b0;
              done       <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
        end

        RUN: begin
          // Core running; beats are ignored until the next reset.
        end

        ERROR: begin
          // Sticky: core stays in reset until the next reset.
        end

        default: begin
          // Unreachable encodings park in ERROR rather than release the core.
          state      <= ERROR;
          error      <= 1'b1;
          load_ready <= 1'b0;
          core_reset <= 1'b1;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule : imem_boot_loader

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: self-checking bench for imem_boot_loader (ADDR_W=2, RESET_HOLD=4).
// Latency: n/a. Stimulus drives beats at negedges; a monitor checks writes at negedges.
// Backpressure: the driver holds each beat until load_ready is seen high.
module tb_imem_boot_loader;

  localparam int ADDR_W     = 2;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int RESET_HOLD = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_valid = 1'b0;
  logic [31:0]       load_data = '0;
  logic              load_last = 1'b0;
  logic              load_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  imem_boot_loader #(.ADDR_W(ADDR_W), .RESET_HOLD(RESET_HOLD)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_reset   (core_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; read at negedges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected write: address, data, edge it is accepted on, count after it.
  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
    int          wl;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         mon_w;
  logic [31:0] mem [DEPTH];

  // Reference model of the image, kept as plain counters and flags.
  int          m_words;
  logic [31:0] m_sum;
  bit          ended;
  bit          exp_err;
  int          exp_fall;

  logic [31:0] img_d[$];
  bit          img_l[$];

  task automatic model_clear();
    m_words  = 0;
    m_sum    = '0;
    ended    = 0;
    exp_err  = 0;
    exp_fall = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input logic [31:0] d, input bit last, input int e);
`ifdef BOOT_CHECKSUM_EN
    if (last) begin
      ended    = 1;
      exp_err  = (d != m_sum);
      exp_fall = e + RESET_HOLD;
      return;
    end
`endif
    if (m_words == DEPTH) begin
      ended   = 1;
      exp_err = 1;
      return;
    end
    exp_q.push_back('{addr: m_words, data: d, cyc: e, wl: m_words + 1});
    m_words++;
    m_sum += d;
    if (last) begin
      ended    = 1;
      exp_err  = 0;
      exp_fall = e + 1 + RESET_HOLD;
    end
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 1, 0);
      end else begin
        mon_w = exp_q.pop_front();
        chk("wr_addr", imem_addr, mon_w.addr);
        chk("wr_data", imem_wdata, mon_w.data);
        chk("wr_cycle", cyc, mon_w.cyc);
        chk("wr_count", words_loaded, mon_w.wl);
        mem[imem_addr] = imem_wdata;
      end
    end
  end

  // Called at a negedge; optionally presents a beat during reset, which must be dropped.
  task automatic do_reset(input int n, input bit hold_valid);
    reset      = 1'b1;
    load_valid = hold_valid;
    load_data  = $urandom;
    load_last  = 1'b0;
    repeat (n) @(negedge clk);
    load_valid = 1'b0;
    model_clear();
    chk("rst_ready", load_ready, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_words", words_loaded, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("load_ready_after_idle", load_ready, 1);
  endtask

  task automatic push_beat(input logic [31:0] d, input bit l);
    img_d.push_back(d);
    img_l.push_back(l);
  endtask

  // Drive up to n beats of img_d/img_l with random idle gaps; stop early when
  // the model says the image has ended or stop_after beats were accepted.
  task automatic drive_image(input int n, input int gmin, input int gmax, input int stop_after);
    int acc = 0;
    for (int i = 0; i < n && !ended && acc < stop_after; i++) begin
      int g;
      bit got;
      g = $urandom_range(gmax, gmin);
      load_valid = 1'b0;
      repeat (g) begin
        load_data = $urandom;
        load_last = 1'($urandom_range(1, 0));
        @(negedge clk);
      end
      load_valid = 1'b1;
      load_data  = img_d[i];
      load_last  = img_l[i];
      got = 0;
      for (int t = 0; t < 20 && !got; t++) begin
        if (load_ready) begin
          got = 1;
          model_accept(img_d[i], img_l[i], cyc + 1);
        end
        @(negedge clk);
      end
      if (!got) chk("accept_timeout", 0, 1);
      acc++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic check_outcome();
    if (!ended) begin
      chk("image_end", 0, 1);
      return;
    end
    if (exp_err) begin
      chk("err_flag", error, 1);
      chk("err_core_reset", core_reset, 1);
      chk("err_ready", load_ready, 0);
      chk("err_done", done, 0);
      chk("err_words", words_loaded, m_words);
      repeat (6) @(negedge clk);
      chk("err_sticky", {error, core_reset}, 2'b11);
    end else begin
      int t = 0;
      while (core_reset && t < 40) begin
        @(negedge clk);
        t++;
      end
      chk("release_cycle", cyc, exp_fall);
      chk("run_done", done, 1);
      chk("run_error", error, 0);
      chk("run_words", words_loaded, m_words);
      chk("run_ready", load_ready, 0);
      load_valid = 1'b1;
      load_data  = $urandom;
      load_last  = 1'b1;
      repeat (3) @(negedge clk);
      chk("run_ignores_beats", {load_ready, done, core_reset}, 3'b010);
      load_valid = 1'b0;
      load_last  = 1'b0;
    end
    chk("pending_writes", exp_q.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    do_reset(5, 0);

    // Basic load, back-to-back.
    img_d.delete(); img_l.delete();
    push_beat(32'h20080005, 0); push_beat(32'h20090007, 0); push_beat(32'h01095020, 1);
    drive_image(3, 0, 0, 3);
    check_outcome();

    // Same image with two idle cycles before every beat.
    do_reset(2, 0);
    drive_image(3, 2, 2, 3);
    check_outcome();

    // Overflow: DEPTH+1 non-last beats.
    do_reset(2, 0);
    img_d.delete(); img_l.delete();
    for (int i = 0; i < DEPTH + 1; i++) push_beat($urandom, 0);
    drive_image(DEPTH + 1, 0, 1, DEPTH + 1);
    check_outcome();

    // Exact fill: last beat at index DEPTH-1.
    do_reset(2, 0);
    img_d.delete(); img_l.delete();
    for (int i = 0; i < DEPTH; i++) push_beat($urandom, i == DEPTH - 1);
    drive_image(DEPTH, 0, 0, DEPTH);
    check_outcome();

    // Reset mid-load with a beat presented during reset, then reload.
    do_reset(2, 0);
    img_d.delete(); img_l.delete();
    for (int i = 0; i < 4; i++) push_beat($urandom, i == 3);
    drive_image(4, 0, 0, 2);
    do_reset(2, 1);
    img_d.delete(); img_l.delete();
    push_beat(32'hAAAA0000, 0); push_beat(32'hBBBB0000, 1);
    drive_image(2, 0, 1, 2);
    check_outcome();
`ifndef BOOT_CHECKSUM_EN
    chk("mem0_reloaded", mem[0], 32'hAAAA0000);
    chk("mem1_reloaded", mem[1], 32'hBBBB0000);
`endif

`ifdef BOOT_CHECKSUM_EN
    // Checksum match and mismatch.
    do_reset(2, 0);
    img_d.delete(); img_l.delete();
    push_beat(32'h1, 0); push_beat(32'h2, 0); push_beat(32'h3, 1);
    drive_image(3, 0, 0, 3);
    check_outcome();
    chk("csum_ok_words", words_loaded, 2);
    do_reset(2, 0);
    img_d.delete(); img_l.delete();
    push_beat(32'h1, 0); push_beat(32'h2, 0); push_beat(32'h4, 1);
    drive_image(3, 0, 0, 3);
    check_outcome();
    chk("csum_bad_error", error, 1);
`endif

    // Randomized images: lengths around the capacity, random gaps and data.
    for (int it = 0; it < 25; it++) begin
      int          n;
      bit          has_last;
      logic [31:0] d;
      logic [31:0] s;
      do_reset($urandom_range(3, 1), 1'($urandom_range(1, 0)));
      has_last = ($urandom_range(3, 0) != 0);
      n = has_last ? $urandom_range(DEPTH + 1, 1) : DEPTH + 1;
      img_d.delete(); img_l.delete();
      s = '0;
      for (int i = 0; i < n; i++) begin
        d = $urandom;
`ifdef BOOT_CHECKSUM_EN
        if (has_last && i == n - 1 && $urandom_range(1, 0) == 1) d = s;
`endif
        push_beat(d, has_last && i == n - 1);
        s += d;
      end
      drive_image(n, 0, $urandom_range(2, 0), n);
      check_outcome();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_imem_boot_loader
